// File: rtl/upct_target_encoder.sv
// Turns full-PC branch targets into (upct index, lower PC, tag) via a 2-entry request FIFO and upct lookup.
// Optional same-upper-PC shortcut that skips the upct lookup: define UPCT_TARGET_ENCODER_BYPASS_EN.
module upct_target_encoder #(
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int UPPER_PC_WIDTH   = 19,
  parameter int TAG_WIDTH        = 8,
  localparam int LOWER_PC_WIDTH  = 31 - UPPER_PC_WIDTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [31:0]                 i_req_target_PC,
  input  logic [TAG_WIDTH-1:0]        i_req_tag,
  output logic                        o_update0_valid,
  output logic [31:0]                 o_update0_start_full_PC,
  input  logic [LOG_UPCT_ENTRIES-1:0] i_update1_upct_index,
  output logic                        o_cmp_valid,
  input  logic                        i_cmp_ready,
  output logic [LOG_UPCT_ENTRIES-1:0] o_cmp_upct_index,
  output logic [LOWER_PC_WIDTH-1:0]   o_cmp_lower_PC,
  output logic [TAG_WIDTH-1:0]        o_cmp_tag
);

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_WAIT, S_OUT} state_t;

  state_t                      r_state;
  logic [31:0]                 r_fifo_pc  [2];
  logic [TAG_WIDTH-1:0]        r_fifo_tag [2];
  logic                        r_wr_ptr;
  logic                        r_rd_ptr;
  logic [1:0]                  r_count;
  logic                        r_req_ready;
  logic [LOG_UPCT_ENTRIES-1:0] r_index;
  logic                        r_update0_valid;
  logic [31:0]                 r_update0_pc;
  logic                        r_cmp_valid;
  logic [LOWER_PC_WIDTH-1:0]   r_cmp_lower;
  logic [TAG_WIDTH-1:0]        r_cmp_tag;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_dispatch;
  logic [1:0]                  w_count_after_pop;
  logic [1:0]                  w_count_next;
  logic                        w_next_head_valid;
  logic [31:0]                 w_next_head_pc;
  logic [TAG_WIDTH-1:0]        w_next_head_tag;
  logic                        w_bypass_hit;
  logic [LOG_UPCT_ENTRIES-1:0] w_bypass_index;

  assign w_push            = i_req_valid & r_req_ready;
  assign w_pop             = (r_state == S_OUT) & i_cmp_ready;
  assign w_dispatch        = (r_state == S_IDLE) | w_pop;
  assign w_count_after_pop = r_count - {1'b0, w_pop};
  assign w_count_next      = w_count_after_pop + {1'b0, w_push};

  // Head as it will be after this cycle's pop/push; an empty FIFO hands over the incoming request.
  assign w_next_head_valid = (w_count_after_pop != 2'd0) | w_push;
  assign w_next_head_pc    = (w_count_after_pop != 2'd0) ? r_fifo_pc[r_rd_ptr ^ w_pop]  : i_req_target_PC;
  assign w_next_head_tag   = (w_count_after_pop != 2'd0) ? r_fifo_tag[r_rd_ptr ^ w_pop] : i_req_tag;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]  <= '0;
        r_fifo_tag[i] <= '0;
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]  <= i_req_target_PC;
        r_fifo_tag[r_wr_ptr] <= i_req_tag;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count     <= w_count_next;
      // Registered from the post-update count, so a pop never frees the slot within the same cycle.
      r_req_ready <= (w_count_next != 2'd2);
    end
  end

`ifdef UPCT_TARGET_ENCODER_BYPASS_EN
  logic [UPPER_PC_WIDTH-1:0]   r_last_upper;
  logic [LOG_UPCT_ENTRIES-1:0] r_last_index;
  logic                        r_last_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_upper <= '0;
      r_last_index <= '0;
      r_last_valid <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_last_upper <= r_fifo_pc[r_rd_ptr][31:32-UPPER_PC_WIDTH];
      r_last_index <= i_update1_upct_index;
      r_last_valid <= 1'b1;
    end
  end

  assign w_bypass_hit   = r_last_valid & (w_next_head_pc[31:32-UPPER_PC_WIDTH] == r_last_upper);
  assign w_bypass_index = r_last_index;
`else
  assign w_bypass_hit   = 1'b0;
  assign w_bypass_index = '0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= S_IDLE;
      r_index         <= '0;
      r_update0_valid <= 1'b0;
      r_update0_pc    <= '0;
      r_cmp_valid     <= 1'b0;
      r_cmp_lower     <= '0;
      r_cmp_tag       <= '0;
    end else begin
      r_update0_valid <= 1'b0;
      r_update0_pc    <= '0;
      unique case (r_state)
        S_UPD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_index     <= i_update1_upct_index;
          r_cmp_valid <= 1'b1;
          r_cmp_lower <= r_fifo_pc[r_rd_ptr][LOWER_PC_WIDTH:1];
          r_cmp_tag   <= r_fifo_tag[r_rd_ptr];
          r_state     <= S_OUT;
        end
        default: begin
          // IDLE, or OUT being accepted: pick the path for the next head; OUT otherwise holds.
          if (w_dispatch) begin
            r_cmp_valid <= 1'b0;
            r_index     <= '0;
            r_cmp_lower <= '0;
            r_cmp_tag   <= '0;
            if (!w_next_head_valid) begin
              r_state <= S_IDLE;
            end else if (w_bypass_hit) begin
              r_state     <= S_OUT;
              r_index     <= w_bypass_index;
              r_cmp_valid <= 1'b1;
              r_cmp_lower <= w_next_head_pc[LOWER_PC_WIDTH:1];
              r_cmp_tag   <= w_next_head_tag;
            end else begin
              r_state         <= S_UPD;
              r_update0_valid <= 1'b1;
              r_update0_pc    <= w_next_head_pc;
            end
          end
        end
      endcase
    end
  end

  assign o_req_ready             = r_req_ready;
  assign o_update0_valid         = r_update0_valid;
  assign o_update0_start_full_PC = r_update0_pc;
  assign o_cmp_valid             = r_cmp_valid;
  assign o_cmp_upct_index        = r_index;
  assign o_cmp_lower_PC          = r_cmp_lower;
  assign o_cmp_tag               = r_cmp_tag;

endmodule
